// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x fractional oversampling and 2-of-3 bit voting.
// Ports: sys_clk_i/sys_rst_n_i, uart_rx_i line, uart_rd_i/uart_dat_o/uart_valid_o host side, error flags.
module uart_rx #(
  parameter int unsigned CLK_HZ = 40_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  output logic       uart_ovr_o,
  output logic       uart_frm_err_o,
  output logic       uart_busy
);

  localparam logic [31:0] INC = 32'(16 * BAUD);
  localparam logic [31:0] LIM = 32'(CLK_HZ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic        rx_m, rx_s;
  logic [31:0] acc_q, sum;
  logic [3:0]  cnt_q;
  logic        s7_q, s8_q;
  logic [7:0]  sh_q;
  logic        armed_q;
  logic [7:0]  dat_q;
  logic        valid_q, ovr_q, ferr_q;

  logic tick, mid, endb, maj;
  logic start_go, good, bad, rd_ok;

  assign sum  = acc_q + INC;
  assign tick = (sum >= LIM);
  assign mid  = tick && (cnt_q == 4'd9);
  assign endb = tick && (cnt_q == 4'd15);
  // the cnt=9 sample is the live line value
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

  assign start_go = (state_q == IDLE) && armed_q && !rx_s;
  assign good     = (state_q == STOP) && mid && maj;
  assign bad      = (state_q == STOP) && mid && !maj;
  assign rd_ok    = uart_rd_i && valid_q;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        if (mid && maj) begin
          state_d = IDLE;
        end else if (endb) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (endb) begin
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      STOP: begin
        // leave early so the next start edge is not missed
        if (mid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      acc_q   <= 32'd0;
      cnt_q   <= 4'd0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      sh_q    <= 8'h00;
      armed_q <= 1'b0;
      dat_q   <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m <= uart_rx_i;
      rx_s <= rx_m;

      // realign the bit phase to the start edge
      if (start_go) begin
        acc_q <= 32'd0;
        cnt_q <= 4'd0;
      end else begin
        acc_q <= tick ? (sum - LIM) : sum;
        if (tick) cnt_q <= cnt_q + 4'd1;
      end

      if (tick && (cnt_q == 4'd7)) s7_q <= rx_s;
      if (tick && (cnt_q == 4'd8)) s8_q <= rx_s;

      if ((state_q == DATA) && mid) sh_q <= {maj, sh_q[7:1]};

      // after a break the line must go idle before a new frame
      if (bad) armed_q <= 1'b0;
      else if ((state_q == IDLE) && rx_s) armed_q <= 1'b1;

      ferr_q <= bad;

      if (good) begin
        dat_q   <= sh_q;
        valid_q <= 1'b1;
        if (rd_ok) ovr_q <= 1'b0;
        else if (valid_q) ovr_q <= 1'b1;
      end else if (rd_ok) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign uart_dat_o     = dat_q;
  assign uart_valid_o   = valid_q;
  assign uart_ovr_o     = ovr_q;
  assign uart_frm_err_o = ferr_q;
  assign uart_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx.
// Drives serial frames and checks the host-side outputs.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 40_000_000;
  localparam int unsigned BAUD   = 115200;
  localparam real CPB = real'(CLK_HZ) / real'(BAUD);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd;
  logic [7:0] dat;
  logic       valid, ovr, ferr, busy;

  int passed = 0;
  int total  = 0;
  int frm_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];

  always #12.5 clk = ~clk;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .uart_rx_i      (rx),
    .uart_rd_i      (rd),
    .uart_dat_o     (dat),
    .uart_valid_o   (valid),
    .uart_ovr_o     (ovr),
    .uart_frm_err_o (ferr),
    .uart_busy      (busy)
  );

  always @(negedge clk) begin
    if (ferr === 1'b1) frm_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_bits(input real nb);
    rx = 1'b1;
    repeat (int'(nb * CPB)) @(negedge clk);
  endtask

  task automatic send_bits(input logic [9:0] f, input int nb,
                           input real cpb);
    real t;
    int  done;
    int  n;
    t = 0.0;
    done = 0;
    for (int i = 0; i < nb; i++) begin
      rx = f[i];
      t += cpb;
      n = int'(t) - done;
      repeat (n) @(negedge clk);
      done += n;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input real cpb);
    if (stop) exp_q.push_back(d);
    send_bits({stop, d, 1'b0}, 10, cpb);
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (valid !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_valid"}, {7'd0, valid}, 8'h01);
    if (exp_q.size() > 0) chk({tag, "_dat"}, dat, exp_q.pop_front());
    else chk({tag, "_sb_empty"}, 8'h01, 8'h00 ^ {7'd0, valid});
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rd = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dat", dat, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_ovr", {7'd0, ovr}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;

    // 1: idle line
    idle_bits(20.0);
    chk("idle_valid", {7'd0, valid}, 8'h00);
    chk("idle_ovr", {7'd0, ovr}, 8'h00);
    chk("idle_frm", 8'(frm_cnt), 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'h00);

    // 2: single byte and read
    send_byte(8'hA5, 1'b1, CPB);
    wait_valid("a5");
    do_read();
    chk("a5_rd_valid", {7'd0, valid}, 8'h00);
    idle_bits(1.0);

    // 3: short glitch
    busy_cnt = 0;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    idle_bits(1.0);
    chk("glitch_busy_seen", 8'(busy_cnt != 0), 8'h01);
    chk("glitch_busy_end", {7'd0, busy}, 8'h00);
    chk("glitch_valid", {7'd0, valid}, 8'h00);

    // 4: framing error then break
    frm_cnt = 0;
    send_byte(8'h3C, 1'b0, CPB);
    rx = 1'b0;
    repeat (int'(30.0 * CPB)) @(negedge clk);
    chk("brk_frm_cnt", 8'(frm_cnt), 8'd1);
    chk("brk_valid", {7'd0, valid}, 8'h00);
    chk("brk_dat_kept", dat, 8'hA5);
    idle_bits(2.0);
    send_byte(8'h81, 1'b1, CPB);
    wait_valid("x81");
    chk("x81_frm_cnt", 8'(frm_cnt), 8'd1);
    do_read();
    idle_bits(1.0);

    // 5: overrun
    send_byte(8'h55, 1'b1, CPB);
    wait_valid("x55");
    chk("x55_ovr", {7'd0, ovr}, 8'h00);
    send_byte(8'h0F, 1'b1, CPB);
    wait_valid("x0f");
    chk("x0f_ovr", {7'd0, ovr}, 8'h01);
    do_read();
    chk("ovr_rd_valid", {7'd0, valid}, 8'h00);
    chk("ovr_rd_ovr", {7'd0, ovr}, 8'h00);
    idle_bits(1.0);

    // 6: baud tolerance
    send_byte(8'hC3, 1'b1, CPB / 1.03);
    wait_valid("c3_fast");
    do_read();
    idle_bits(1.0);
    send_byte(8'hC3, 1'b1, CPB / 0.97);
    wait_valid("c3_slow");
    idle_bits(1.0);

    // reset during bit 4, with an unread byte held
    send_bits({1'b1, 8'h0F, 1'b0}, 5, CPB);
    rx = 1'b0;
    repeat (int'(CPB / 2.0)) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_dat", dat, 8'h00);
    chk("mid_rst_valid", {7'd0, valid}, 8'h00);
    chk("mid_rst_ovr", {7'd0, ovr}, 8'h00);
    chk("mid_rst_busy", {7'd0, busy}, 8'h00);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    frm_cnt = 0;
    idle_bits(12.0);
    chk("post_rst_valid", {7'd0, valid}, 8'h00);
    chk("post_rst_busy", {7'd0, busy}, 8'h00);
    chk("post_rst_frm", 8'(frm_cnt), 8'd0);
    chk("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
